fp_exception_pipe: RTL and testbench
====================================

# fp_exception_pipe

Parametrised, pipelined special-value classifier for the FPU front end. It generalises the combinational addition-only exception check to all four FP operations and configurable exponent/mantissa widths. It resolves IEEE-style special cases (NaN, ±inf, zero operands), produces the bypass result, and keeps sticky exception flags. It sits in parallel with the arithmetic datapath; when `OP_IS_EXCEPTION` is high, the FPU output mux selects `RESULT` from this block.

## Interface
- `EXP_W`, default 4: exponent field width.
- `MAN_W`, default 3: mantissa field width; word width `W = 1+EXP_W+MAN_W`, with sign at the MSB.
- `PIPE_DEPTH`, default 2: number of register stages, legal range 1..4.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST_N` input, 1 bit: asynchronous reset, active-low.
- `IN_VALID` input, 1 bit: operation presented.
- `IN_READY` output, 1 bit: block accepts the operation this cycle.
- `FP_OPERATION` input, 2 bits: 00 add, 01 sub, 10 mul, 11 div.
- `OP_A`, `OP_B` input, W bits: operands.
- `OUT_VALID` output, 1 bit: result stage holds a valid entry.
- `OUT_READY` input, 1 bit: downstream accepts.
- `OP_IS_EXCEPTION` output, 1 bit: asserted when `EXC_CODE` is not 0.
- `EXC_CODE` output, 3 bits: 0 none, 1 NaN propagate, 2 invalid, 3 inf result, 4 divide-by-zero, 5 zero result.
- `RESULT` output, W bits: special-path result. All zeros when code is 0.
- `FLAG_CLR` input, 1 bit: clears the sticky flags.
- `FLAGS` output, 3 bits: sticky flags. Bit 0 invalid, bit 1 divide-by-zero, bit 2 NaN input seen.

## Operation
- **Operand classes:**
  - Exponent all ones with mantissa 0 is inf.
  - Exponent all ones with mantissa non-zero is NaN.
  - Exponent 0 with mantissa 0 is zero.
  - Everything else is finite, including subnormals.
- **Canonical qNaN:** sign 0, exponent all ones, mantissa MSB 1, remaining mantissa bits 0.
- **Subtraction:** identical to addition with the sign of B inverted.
- **Rule priority, first match wins:**
  - Either operand NaN: code 1, qNaN.
  - Add with opposite-sign infs: code 2, qNaN.
  - Mul with zero × inf in either order: code 2, qNaN.
  - Div with inf/inf or 0/0: code 2, qNaN.
  - Div with finite non-zero / zero: code 4, inf carrying signA^signB.
  - Add with any inf operand: code 3, that inf (effective B sign).
  - Mul/div with an inf numerator or inf factor: code 3, inf carrying signA^signB.
  - Div with finite / inf: code 5, zero carrying signA^signB.
  - Otherwise: code 0.
- **Classification stage:** classification is computed combinationally from the inputs and captured in stage 1. Later stages only delay.
- **Stall control:**
  - `advance = OUT_READY | ~OUT_VALID`.
  - All stages shift when `advance` is 1 and hold when it is 0.
  - `IN_READY = advance`.
  - A stage loads `IN_VALID & IN_READY` as its valid bit, so bubbles propagate and are not collapsed.
- **Sticky flags:**
  - Updated when an entry is accepted into stage 1.
  - `FLAGS <= (FLAG_CLR ? 0 : FLAGS) | new_bits`. A same-cycle set wins over clear.
- **Reset:** asynchronous on `RST_N` low. All stage valid bits, `OUT_VALID`, `EXC_CODE`, `RESULT`, `OP_IS_EXCEPTION` and `FLAGS` go to 0 immediately. In-flight entries are discarded.

## Timing
- Latency is `PIPE_DEPTH` cycles from accepting handshake to `OUT_VALID`, with no stalls.
- Throughput is one operation per cycle.
- Output hold: while `OUT_VALID & ~OUT_READY`, all outputs stay stable and `IN_READY` is 0 in the same cycle (combinational path from `OUT_READY`).
- No combinational path from `OP_A`/`OP_B` to any output.
- `FLAGS` reflects an accepted operation one cycle after acceptance, independent of pipeline depth.
- `FLAG_CLR` takes effect on the next edge.
- After `RST_N` deasserts, `IN_READY` is 1 and the first acceptance is possible on the first rising edge.

## Configuration
- `FP_EXC_STICKY_FLAGS_EN`:
  - Defined: sticky flag register and `FLAG_CLR` logic are present as described.
  - Undefined: `FLAGS` is tied to 3'b000, `FLAG_CLR` is ignored, and no flag registers are instantiated.
  - Pipeline behaviour is identical in both cases.

## Test plan
All scenarios use E4M3 defaults: +inf 8'h78, -inf 8'hF8, qNaN 8'h7C, 1.0 8'h38, -0 8'h80.
- **Invalid add:** `PIPE_DEPTH`=2, add 8'h78 + 8'hF8. Two cycles later `OUT_VALID`=1, code 2, `RESULT` 8'h7C, `OP_IS_EXCEPTION`=1; `FLAGS`=3'b001 one cycle after acceptance.
- **Divide-by-zero and zero×inf:**
  - Div 8'h38 / 8'h80 gives code 4, `RESULT` 8'hF8, `FLAGS`[1]=1.
  - Mul 8'h00 × 8'hF8 gives code 2, `RESULT` 8'h7C.
- **NaN propagation and sub-to-inf:**
  - Sub 8'h38 − 8'h79 gives code 1, 8'h7C, `FLAGS`[2]=1.
  - Sub 8'h38 − 8'h78 gives code 3, 8'hF8.
- **Backpressure:** `OUT_READY`=0 with 3 back-to-back ops. `IN_READY` drops once the output stage is full; after release, all 3 emerge in order with unchanged values and none lost or duplicated.
- **Reset mid-operation:** pulse `RST_N` low between clock edges with 2 entries in flight. `OUT_VALID`, `EXC_CODE` and `FLAGS` go to 0 before the next edge; nothing is emitted after release.
- **Clear/set collision:** `FLAG_CLR`=1 in the same cycle an invalid op is accepted, with `FLAGS`=3'b110 beforehand. Result is `FLAGS`=3'b001. With `FP_EXC_STICKY_FLAGS_EN` undefined, `FLAGS` stays 0.

Source files
------------

// File: rtl/fp_exception_pipe.sv
// fp_exception_pipe: pipelined FP special-value classifier (NaN/inf/zero)
// with valid/ready stall control and optional sticky exception flags.
//
// Ports:
//   CLK, RST_N             clock, async active-low reset
//   IN_VALID/IN_READY      input handshake (IN_READY = advance)
//   FP_OPERATION           00 add, 01 sub, 10 mul, 11 div
//   OP_A, OP_B             operands {sign, exp[EXP_W], man[MAN_W]}
//   OUT_VALID/OUT_READY    output handshake
//   OP_IS_EXCEPTION        EXC_CODE != 0
//   EXC_CODE               0 none,1 NaN,2 invalid,3 inf,4 div0,5 zero
//   RESULT                 special-path result, zero when code is 0
//   FLAG_CLR, FLAGS        sticky flags {nan_seen, div0, invalid}
//
// Build option: define FP_EXC_STICKY_FLAGS_EN to include the sticky
// flag register; otherwise FLAGS is tied to zero.
module fp_exception_pipe #(
    parameter int EXP_W      = 4,
    parameter int MAN_W      = 3,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [1:0]             FP_OPERATION,
    input  logic [EXP_W+MAN_W:0]   OP_A,
    input  logic [EXP_W+MAN_W:0]   OP_B,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OP_IS_EXCEPTION,
    output logic [2:0]             EXC_CODE,
    output logic [EXP_W+MAN_W:0]   RESULT,
    input  logic                   FLAG_CLR,
    output logic [2:0]             FLAGS
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam int L = PIPE_DEPTH - 1;

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

    logic advance;
    logic accept;

    // operand classification
    logic ones_a, ones_b, ez_a, ez_b, mz_a, mz_b;
    logic inf_a, inf_b, nan_a, nan_b, zero_a, zero_b, fin_a;
    logic sa, sb_eff, sp;
    logic is_add, is_mul, is_div;

    logic [2:0]   cls_code;
    logic [W-1:0] cls_res;

    assign ones_a = &OP_A[W-2:MAN_W];
    assign ones_b = &OP_B[W-2:MAN_W];
    assign ez_a   = ~|OP_A[W-2:MAN_W];
    assign ez_b   = ~|OP_B[W-2:MAN_W];
    assign mz_a   = ~|OP_A[MAN_W-1:0];
    assign mz_b   = ~|OP_B[MAN_W-1:0];

    assign inf_a  = ones_a & mz_a;
    assign inf_b  = ones_b & mz_b;
    assign nan_a  = ones_a & ~mz_a;
    assign nan_b  = ones_b & ~mz_b;
    assign zero_a = ez_a & mz_a;
    assign zero_b = ez_b & mz_b;
    assign fin_a  = ~ones_a & ~zero_a;

    assign is_add = ~FP_OPERATION[1];
    assign is_mul = (FP_OPERATION == 2'b10);
    assign is_div = (FP_OPERATION == 2'b11);

    // subtraction is addition with B's sign flipped
    assign sa     = OP_A[W-1];
    assign sb_eff = OP_B[W-1] ^ (FP_OPERATION == 2'b01);
    assign sp     = OP_A[W-1] ^ OP_B[W-1];

    // first matching rule wins, so this is a priority chain
    always_comb begin
        cls_code = 3'd0;
        cls_res  = '0;
        if (nan_a | nan_b) begin
            cls_code = 3'd1;
            cls_res  = QNAN;
        end else if (is_add & inf_a & inf_b & (sa ^ sb_eff)) begin
            cls_code = 3'd2;
            cls_res  = QNAN;
        end else if (is_mul & ((zero_a & inf_b) | (inf_a & zero_b))) begin
            cls_code = 3'd2;
            cls_res  = QNAN;
        end else if (is_div & ((inf_a & inf_b) | (zero_a & zero_b))) begin
            cls_code = 3'd2;
            cls_res  = QNAN;
        end else if (is_div & fin_a & zero_b) begin
            cls_code = 3'd4;
            cls_res  = {sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (is_add & (inf_a | inf_b)) begin
            cls_code = 3'd3;
            cls_res  = {inf_a ? sa : sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((is_mul & (inf_a | inf_b)) | (is_div & inf_a)) begin
            cls_code = 3'd3;
            cls_res  = {sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (is_div & inf_b) begin
            // NaN/inf numerators are already handled: A is zero or finite
            cls_code = 3'd5;
            cls_res  = {sp, {(W-1){1'b0}}};
        end
    end

    // pipeline stages
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [2:0]            code_q [PIPE_DEPTH];
    logic [2:0]            code_d [PIPE_DEPTH];
    logic [W-1:0]          res_q  [PIPE_DEPTH];
    logic [W-1:0]          res_d  [PIPE_DEPTH];

    assign OUT_VALID       = vld_q[L];
    assign EXC_CODE        = code_q[L];
    assign RESULT          = res_q[L];
    assign OP_IS_EXCEPTION = |code_q[L];

    // whole pipe stalls together so bubbles are never collapsed
    assign advance  = OUT_READY | ~OUT_VALID;
    assign IN_READY = advance;
    assign accept   = IN_VALID & advance;

    always_comb begin
        vld_d  = vld_q;
        code_d = code_q;
        res_d  = res_q;
        if (advance) begin
            vld_d[0]  = accept;
            code_d[0] = accept ? cls_code : 3'd0;
            res_d[0]  = accept ? cls_res : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                vld_d[i]  = vld_q[i-1];
                code_d[i] = code_q[i-1];
                res_d[i]  = res_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                code_q[i] <= 3'd0;
                res_q[i]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                code_q[i] <= code_d[i];
                res_q[i]  <= res_d[i];
            end
        end
    end

`ifdef FP_EXC_STICKY_FLAGS_EN
    logic [2:0] flags_q, flags_d, new_bits;

    // set wins over a same-cycle clear
    always_comb begin
        new_bits = 3'b000;
        if (accept) begin
            new_bits = {cls_code == 3'd1, cls_code == 3'd4, cls_code == 3'd2};
        end
        flags_d = (FLAG_CLR ? 3'b000 : flags_q) | new_bits;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign FLAGS = flags_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = FLAG_CLR;
    assign FLAGS = 3'b000;
`endif

endmodule

// File: tb/tb_fp_exception_pipe.sv
// tb_fp_exception_pipe: directed + randomized checks of fp_exception_pipe
// against a queue-based reference model (E4M3, PIPE_DEPTH=2).
module tb_fp_exception_pipe;

    logic       CLK;
    logic       RST_N;
    logic       IN_VALID;
    logic       IN_READY;
    logic [1:0] FP_OPERATION;
    logic [7:0] OP_A, OP_B;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OP_IS_EXCEPTION;
    logic [2:0] EXC_CODE;
    logic [7:0] RESULT;
    logic       FLAG_CLR;
    logic [2:0] FLAGS;

`ifdef FP_EXC_STICKY_FLAGS_EN
    localparam logic [2:0] SM = 3'b111;
`else
    localparam logic [2:0] SM = 3'b000;
`endif

    fp_exception_pipe #(.EXP_W(4), .MAN_W(3), .PIPE_DEPTH(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OP_IS_EXCEPTION(OP_IS_EXCEPTION), .EXC_CODE(EXC_CODE),
        .RESULT(RESULT), .FLAG_CLR(FLAG_CLR), .FLAGS(FLAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // class: 0 zero, 1 finite, 2 inf, 3 nan
    function automatic int kind(input logic [7:0] v);
        int e, m;
        e = int'(v[6:3]);
        m = int'(v[2:0]);
        if (e == 15) return (m == 0) ? 2 : 3;
        if (e == 0 && m == 0) return 0;
        return 1;
    endfunction

    function automatic void ref_op(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, output logic [2:0] code,
                                   output logic [7:0] res);
        int ka, kb;
        bit add, mul, div, sa, sbe, sp;
        ka  = kind(a);
        kb  = kind(b);
        add = (op == 0) || (op == 1);
        mul = (op == 2);
        div = (op == 3);
        sa  = a[7];
        sbe = (op == 1) ? !b[7] : b[7];
        sp  = a[7] ^ b[7];
        code = 0;
        res  = 8'h00;
        if (ka == 3 || kb == 3) begin
            code = 1; res = 8'h7C;
        end else if (add && ka == 2 && kb == 2 && sa != sbe) begin
            code = 2; res = 8'h7C;
        end else if (mul && ((ka == 0 && kb == 2) || (ka == 2 && kb == 0))) begin
            code = 2; res = 8'h7C;
        end else if (div && ((ka == 2 && kb == 2) || (ka == 0 && kb == 0))) begin
            code = 2; res = 8'h7C;
        end else if (div && ka == 1 && kb == 0) begin
            code = 4; res = sp ? 8'hF8 : 8'h78;
        end else if (add && (ka == 2 || kb == 2)) begin
            code = 3;
            res  = ((ka == 2) ? sa : sbe) ? 8'hF8 : 8'h78;
        end else if ((mul && (ka == 2 || kb == 2)) || (div && ka == 2)) begin
            code = 3; res = sp ? 8'hF8 : 8'h78;
        end else if (div && kb == 2) begin
            code = 5; res = sp ? 8'h80 : 8'h00;
        end
    endfunction

    logic [10:0] expq [$];
    logic [2:0]  mflags;
    logic [2:0]  m_code, m_nb;
    logic [7:0]  m_res;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            expq.delete();
            mflags <= 3'b000;
        end else begin
            m_nb = 3'b000;
            if (OUT_VALID && OUT_READY && expq.size() > 0)
                void'(expq.pop_front());
            if (IN_VALID && IN_READY) begin
                ref_op(FP_OPERATION, OP_A, OP_B, m_code, m_res);
                expq.push_back({m_code, m_res});
                m_nb = {m_code == 1, m_code == 4, m_code == 2};
            end
            mflags <= SM & ((FLAG_CLR ? 3'b000 : mflags) | m_nb);
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            chk("in_ready", IN_READY, OUT_READY | !OUT_VALID);
            chk("flags", FLAGS, mflags);
            if (OUT_VALID) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", OUT_VALID, 0);
                end else begin
                    chk("code", EXC_CODE, expq[0][10:8]);
                    chk("result", RESULT, expq[0][7:0]);
                    chk("is_exc", OP_IS_EXCEPTION, expq[0][10:8] != 0);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic idle(input int n);
        IN_VALID = 0; FLAG_CLR = 0; OUT_READY = 1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic one(input string n, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] ec, input logic [7:0] er,
                       input logic [2:0] ef);
        @(negedge CLK);
        OUT_READY = 1; FLAG_CLR = 0;
        IN_VALID = 1; FP_OPERATION = op; OP_A = a; OP_B = b;
        @(negedge CLK);
        IN_VALID = 0;
        chk({n, "_flags"}, FLAGS, ef & SM);
        chk({n, "_early"}, OUT_VALID, 0);
        @(negedge CLK);
        chk({n, "_valid"}, OUT_VALID, 1);
        chk({n, "_code"}, EXC_CODE, ec);
        chk({n, "_res"}, RESULT, er);
        chk({n, "_exc"}, OP_IS_EXCEPTION, ec != 0);
    endtask

    logic [2:0] got [$];
    int         spin;

    initial begin
        RST_N = 0; IN_VALID = 0; OUT_READY = 1; FLAG_CLR = 0;
        FP_OPERATION = 0; OP_A = 0; OP_B = 0;
        #3;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_code", EXC_CODE, 0);
        chk("rst_flags", FLAGS, 0);
        #9 RST_N = 1;
        #1 chk("rst_in_ready", IN_READY, 1);

        one("inv_add", 2'b00, 8'h78, 8'hF8, 3'd2, 8'h7C, 3'b001);
        one("div0", 2'b11, 8'h38, 8'h80, 3'd4, 8'hF8, 3'b011);
        one("zero_inf", 2'b10, 8'h00, 8'hF8, 3'd2, 8'h7C, 3'b011);
        one("nan_sub", 2'b01, 8'h38, 8'h79, 3'd1, 8'h7C, 3'b111);
        one("sub_inf", 2'b01, 8'h38, 8'h78, 3'd3, 8'hF8, 3'b111);
        one("div_inf", 2'b11, 8'hB8, 8'h78, 3'd5, 8'h80, 3'b111);
        one("plain", 2'b10, 8'h38, 8'h38, 3'd0, 8'h00, 3'b111);

        // clear/set collision
        @(negedge CLK); FLAG_CLR = 1;
        @(negedge CLK); FLAG_CLR = 0;
        chk("clr_flags", FLAGS, 3'b000);
        one("pre_div0", 2'b11, 8'h38, 8'h80, 3'd4, 8'hF8, 3'b010);
        one("pre_nan", 2'b01, 8'h38, 8'h79, 3'd1, 8'h7C, 3'b110);
        @(negedge CLK);
        IN_VALID = 1; FLAG_CLR = 1;
        FP_OPERATION = 2'b00; OP_A = 8'h78; OP_B = 8'hF8;
        @(negedge CLK);
        IN_VALID = 0; FLAG_CLR = 0;
        chk("collide_flags", FLAGS, 3'b001 & SM);
        idle(3);

        // backpressure: three back-to-back ops into a stalled output
        OUT_READY = 0;
        IN_VALID = 1; FP_OPERATION = 2'b00; OP_A = 8'h78; OP_B = 8'hF8;
        @(negedge CLK);
        FP_OPERATION = 2'b11; OP_A = 8'h38; OP_B = 8'h80;
        @(negedge CLK);
        FP_OPERATION = 2'b01; OP_A = 8'h38; OP_B = 8'h78;
        chk("bp_in_ready", IN_READY, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("bp_hold_valid", OUT_VALID, 1);
            chk("bp_hold_code", EXC_CODE, 3'd2);
            chk("bp_hold_res", RESULT, 8'h7C);
            chk("bp_hold_ready", IN_READY, 0);
        end
        OUT_READY = 1;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            if (OUT_VALID) got.push_back(EXC_CODE);
            @(negedge CLK);
            if (k == 0) IN_VALID = 0;
        end
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_first", got[0], 3'd2);
            chk("bp_second", got[1], 3'd4);
            chk("bp_third", got[2], 3'd3);
        end

        // reset with two entries in flight
        idle(2);
        IN_VALID = 1; FP_OPERATION = 2'b00; OP_A = 8'h78; OP_B = 8'hF8;
        @(negedge CLK);
        FP_OPERATION = 2'b11; OP_A = 8'h38; OP_B = 8'h80;
        @(negedge CLK);
        IN_VALID = 0;
        chk("pre_rst_valid", OUT_VALID, 1);
        chk("pre_rst_code", EXC_CODE, 3'd2);
        #2 RST_N = 0;
        #1;
        chk("mid_rst_valid", OUT_VALID, 0);
        chk("mid_rst_code", EXC_CODE, 0);
        chk("mid_rst_res", RESULT, 0);
        chk("mid_rst_flags", FLAGS, 0);
        #1 RST_N = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("post_rst_quiet", OUT_VALID, 0);
        end

        // randomized traffic, biased toward special operands
        begin
            logic [7:0] sp [10];
            sp = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h79,
                   8'hFF, 8'h38, 8'hB8, 8'h01, 8'h7C};
            for (int c = 0; c < 1500; c++) begin
                @(negedge CLK);
                IN_VALID     = ($urandom_range(0, 3) != 0);
                OUT_READY    = ($urandom_range(0, 9) < 7);
                FLAG_CLR     = ($urandom_range(0, 9) == 0);
                FP_OPERATION = 2'($urandom_range(0, 3));
                OP_A = $urandom_range(0, 1) ? sp[$urandom_range(0, 9)]
                                            : 8'($urandom);
                OP_B = $urandom_range(0, 1) ? sp[$urandom_range(0, 9)]
                                            : 8'($urandom);
            end
        end

        idle(1);
        spin = 0;
        while (OUT_VALID && spin < 20) begin
            @(negedge CLK);
            spin++;
        end
        chk("drain_valid", OUT_VALID, 0);
        chk("drain_queue", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
